// File: rtl/core_types_pkg.sv
// core_types_pkg: shared datapath width and ALU operation encoding
package core_types_pkg;
  localparam int XLEN = 32;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;
  function automatic logic is_shift(alu_op_t op);
    return op inside {ALU_SLL, ALU_SRL, ALU_SRA};
  endfunction
endpackage

// File: rtl/alu_comb.sv
// alu_comb: single-cycle arithmetic, compare and bitwise ops; anything else adds
module alu_comb
  import core_types_pkg::*;
(
  input  alu_op_t          op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  y
);
  always_comb begin
    y = a + b;
    case (op)
      ALU_SUB:  y = a - b;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
  end
endmodule

// File: rtl/serial_alu.sv
// serial_alu: ALU with one-bit-per-cycle shifter and valid/ready handshakes
module serial_alu
  import core_types_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  alu_op_t         in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t          state, state_next;
  alu_op_t         op_q;
  logic [XLEN-1:0] res, comb_y;
  logic [4:0]      cnt;
  logic            accept;
  alu_comb u_comb (.op(in_op), .a(in_a), .b(in_b), .y(comb_y));
  assign in_ready   = rst_n && state == IDLE && !flush;
  assign accept     = in_valid && in_ready;
  assign out_valid  = state == DONE;
  assign out_result = res;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    if (flush) state_next = IDLE;
    else
      case (state)
        IDLE:    if (accept) state_next = (is_shift(in_op) && in_b[4:0] != 5'd0) ? SHIFT : DONE;
        SHIFT:   if (cnt == 5'd1) state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
  end
  // res doubles as the shift working register and the delivered result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      res  <= '0;
      cnt  <= '0;
      op_q <= ALU_ADD;
    end else if (accept) begin
      res  <= is_shift(in_op) ? in_a : comb_y;
      cnt  <= in_b[4:0];
      op_q <= in_op;
    end else if (state == SHIFT && !flush) begin
      res <= op_q == ALU_SLL ? {res[XLEN-2:0], 1'b0}
                             : {op_q == ALU_SRA && res[XLEN-1], res[XLEN-1:1]};
      cnt <= cnt - 5'd1;
    end
endmodule
